// File: rtl/audio_pkg.sv
// Shared types for the PSG attribute write path: address/data widths,
// the arbiter state encoding and the {addr,data} write record.
package audio_pkg;

   localparam int ATTR_ADDR_W = 6;
   localparam int ATTR_DATA_W = 8;

   typedef enum logic [1:0] {
      ARB_IDLE,
      ARB_SYNC_WAIT,
      ARB_BATCH
   } arb_state_t;

   typedef struct packed {
      logic [ATTR_ADDR_W-1:0] addr;
      logic [ATTR_DATA_W-1:0] data;
   } attr_wr_t;

endpackage

// File: rtl/attr_fifo.sv
// Synchronous FIFO of attribute writes; a push while full is accepted
// only when a pop frees the slot in the same cycle.
module attr_fifo
   import audio_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic     clk,
   input  logic     rst,
   input  logic     push,
   input  attr_wr_t wdata,
   input  logic     pop,
   output attr_wr_t rdata,
   output logic     full,
   output logic     empty
);

   localparam int AW = $clog2(DEPTH);

   attr_wr_t       mem [DEPTH];
   logic [AW-1:0]  wr_ptr;
   logic [AW-1:0]  rd_ptr;
   logic [AW:0]    count;
   logic           do_push;
   logic           do_pop;

   assign empty   = (count == '0);
   assign full    = (count == (AW+1)'(DEPTH));
   assign do_pop  = pop & ~empty;
   assign do_push = push & (~full | do_pop);
   assign rdata   = mem[rd_ptr];

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= wdata;
   end

endmodule

// File: rtl/psg_attr_arb.sv
// Shares the PSG attribute write port between buffered host writes and
// atomic sequencer batches, optionally aligned to the next sample.
module psg_attr_arb
   import audio_pkg::*;
#(
   parameter int HOST_DEPTH     = 4,
   parameter int HOST_BURST_MAX = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [ATTR_ADDR_W-1:0] host_addr,
   input  logic [ATTR_DATA_W-1:0] host_wrdata,
   input  logic                   host_write,
   output logic                   host_ovf,
   input  logic                   seq_valid,
   input  logic [ATTR_ADDR_W-1:0] seq_addr,
   input  logic [ATTR_DATA_W-1:0] seq_wrdata,
   input  logic                   seq_last,
   input  logic                   seq_sync,
   output logic                   seq_ready,
   input  logic                   next_sample,
   output logic [ATTR_ADDR_W-1:0] attr_addr,
   output logic [ATTR_DATA_W-1:0] attr_wrdata,
   output logic                   attr_write,
   output logic                   batch_active
);

   localparam int SW = $clog2(HOST_BURST_MAX + 1);
   localparam logic [SW-1:0] STARVE_MAX = SW'(HOST_BURST_MAX);

   arb_state_t     state;
   arb_state_t     state_nxt;
   logic [SW-1:0]  starve_cnt;
   attr_wr_t       head;
   logic           fifo_full;
   logic           fifo_empty;
   logic           fifo_push;
   logic           seq_turn;
   logic           ready_raw;
   logic           seq_grant;
   logic           host_grant;
   logic           drop;

   assign seq_turn  = fifo_empty | (starve_cnt == STARVE_MAX);
   assign ready_raw = (state == ARB_BATCH) |
                      ((state == ARB_IDLE) & ~seq_sync & seq_turn);
   // Gated by reset so the port reads not-ready while held in reset.
   assign seq_ready  = rst & ready_raw;
   assign seq_grant  = seq_valid & seq_ready;
   assign host_grant = ~fifo_empty & ~seq_grant & (state != ARB_BATCH);

   assign fifo_push = host_write & (~fifo_full | host_grant);
   assign drop      = host_write & fifo_full & ~host_grant;

   assign batch_active = (state != ARB_IDLE);

   attr_fifo #(
      .DEPTH (HOST_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (fifo_push),
      .wdata ({host_addr, host_wrdata}),
      .pop   (host_grant),
      .rdata (head),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= ARB_IDLE;
      else      state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ARB_IDLE: begin
            if (seq_valid & seq_sync)
               state_nxt = ARB_SYNC_WAIT;
            else if (seq_grant & ~seq_last)
               state_nxt = ARB_BATCH;
         end
         ARB_SYNC_WAIT: begin
            if (next_sample) state_nxt = ARB_BATCH;
         end
         ARB_BATCH: begin
            if (seq_grant & seq_last) state_nxt = ARB_IDLE;
         end
         default: state_nxt = ARB_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         starve_cnt <= '0;
      end else if (seq_grant | ~seq_valid) begin
         starve_cnt <= '0;
      end else if ((state == ARB_IDLE) & host_grant &
                   (starve_cnt != STARVE_MAX)) begin
         starve_cnt <= starve_cnt + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         attr_addr   <= '0;
         attr_wrdata <= '0;
         attr_write  <= 1'b0;
         host_ovf    <= 1'b0;
      end else begin
         attr_write <= seq_grant | host_grant;
         host_ovf   <= drop;
         if (seq_grant) begin
            attr_addr   <= seq_addr;
            attr_wrdata <= seq_wrdata;
         end else if (host_grant) begin
            attr_addr   <= head.addr;
            attr_wrdata <= head.data;
         end
      end
   end

endmodule

// File: doc/psg_attr_arb.md
# psg_attr_arb

Arbiter and batch sequencer for the PSG attribute write port (attr_addr/attr_wrdata/attr_write). Shares the single write port between host register writes (strobe, no backpressure, buffered in a small FIFO) and a sequencer port (valid/ready) that delivers atomic multi-write batches. Batches can be aligned to the next_sample boundary so all voice updates land in the same output sample. Sits between the register interface/sequencer and the psg instance inside audio.

## Interface
- HOST_DEPTH, 4: host FIFO entries; power of 2, ≥2.
- HOST_BURST_MAX, 4: consecutive host grants allowed while a sequencer beat waits in IDLE.

- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- host_addr  in  6  host attribute address.
- host_wrdata  in  8  host write data.
- host_write  in  1  single-cycle host write strobe.
- host_ovf  out  1  one-cycle pulse: host write dropped, FIFO full.
- seq_valid  in  1  sequencer beat valid.
- seq_addr  in  6  sequencer attribute address.
- seq_wrdata  in  8  sequencer write data.
- seq_last  in  1  beat ends the batch.
- seq_sync  in  1  on first beat of a batch: start batch at next next_sample.
- seq_ready  out  1  sequencer beat accepted when seq_valid & seq_ready.
- next_sample  in  1  sample-boundary pulse from the DAC interface.
- attr_addr  out  6  to psg.
- attr_wrdata  out  8  to psg.
- attr_write  out  1  to psg; one write per cycle max.
- batch_active  out  1  high in SYNC_WAIT or BATCH.

## Operation
- States: IDLE, SYNC_WAIT, BATCH.
- IDLE: if seq_valid & seq_sync -> SYNC_WAIT, no grant to sequencer this cycle. Else grant: sequencer if seq_valid & (FIFO empty | starve_cnt == HOST_BURST_MAX), otherwise host FIFO head if non-empty. seq_ready = ~seq_sync & (FIFO empty | starve_cnt == HOST_BURST_MAX). Accepted sequencer beat with ~seq_last -> BATCH; with seq_last -> stay IDLE.
- starve_cnt: +1 per host grant while seq_valid high in IDLE (saturates); cleared on sequencer grant or when seq_valid low.
- SYNC_WAIT: seq_ready = 0; host FIFO drains. On next_sample -> BATCH. next_sample in the cycle IDLE->SYNC_WAIT is ignored.
- BATCH: seq_ready = 1; no host grants (host writes still enqueue). Beat with seq_last accepted -> IDLE. Gaps (seq_valid low) keep BATCH.
- Host FIFO: push on host_write if not full or if popping same cycle; write when full without pop is dropped, host_ovf pulses. Order preserved.
- Reset: async to IDLE, FIFO emptied, starve_cnt 0; mid-batch reset abandons batch, no partial output after release.

## Timing
- Reset values: attr_addr 0, attr_wrdata 0, attr_write 0, host_ovf 0, seq_ready 0, batch_active 0.
- attr_* registered. Sequencer beat accepted cycle N -> attr_write at N+1.
- Host write cycle N -> FIFO visible N+1 -> attr_write at N+2 minimum.
- host_ovf registered, asserts cycle N+1 for a drop at N.
- Batch of K beats streamed back-to-back: K consecutive attr_write cycles, no host write interleaved.
- seq_ready is combinational from state, FIFO empty, starve_cnt and seq_sync; never from seq_valid.

## Structure
- audio_pkg: ATTR_ADDR_W=6, ATTR_DATA_W=8, arbiter state enum.
- One sub-module: attr_fifo (synchronous FIFO, {addr,data} 14 bits wide, push/pop/full/empty, simultaneous push+pop when full allowed).
- Arbitration FSM, starve_cnt and output registers in psg_attr_arb.

## Test plan
- Host writes (0x00,0x11),(0x01,0x22),(0x02,0x33) on consecutive cycles, seq idle -> attr_write at cycles 2,3,4 in order, data exact.
- Five host writes to full HOST_DEPTH=4 FIFO, no drain possible (BATCH held open) -> fifth dropped, host_ovf one pulse, first four emerge after batch end.
- Sequencer 3-beat batch (addr 0x04..0x06, seq_last on third) with host FIFO holding 2 entries mid-batch -> three seq writes contiguous, host writes follow.
- seq_sync batch, next_sample 10 cycles later -> seq_ready 0 and batch_active 1 until next_sample, first seq attr_write 2 cycles after next_sample pulse.
- Host writes continuous, seq_valid single beat (no sync) -> seq granted after exactly 4 host grants.
- rst low mid-batch -> all outputs 0 immediately, state IDLE, FIFO empty after release.
